// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg : shared widths, state encoding and keystream byte select
// Rev 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_W           = 128;
   localparam int BYTES_PER_BLOCK = 16;
   localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GEN    = 2'd1,
      STREAM = 2'd2
   } state_e;

   // Byte 0 is the most significant byte of the block.
   function automatic logic [7:0] ks_byte(input logic [AES_W-1:0] ks,
                                          input logic [IDX_W-1:0] idx);
      ks_byte = 8'h00;
      for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
         if (idx == IDX_W'(i)) ks_byte = ks[AES_W-1-8*i -: 8];
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctr_inc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ctr_inc : increments the low CTR_W bits of a 128-bit counter block, wrapping
// Rev 1.0
// ---------------------------------------------------------------------------
module ctr_inc
   import aes_pkg::*;
#(
   parameter int CTR_W = 32
) (
   input  logic [AES_W-1:0] blk_in,
   output logic [AES_W-1:0] blk_out
);

   generate
      if (CTR_W >= AES_W) begin : g_full
         assign blk_out = blk_in + AES_W'(1);
      end else begin : g_part
         assign blk_out = {blk_in[AES_W-1:CTR_W], blk_in[CTR_W-1:0] + CTR_W'(1)};
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_ctr_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_ctr_stream : CTR-mode byte stream controller around a combinational AES-128 core
// Rev 1.0
// ---------------------------------------------------------------------------
module aes_ctr_stream
   import aes_pkg::*;
#(
   parameter int CORE_LAT = 1,
   parameter int CTR_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [AES_W-1:0] key_in,
   input  logic [AES_W-1:0] iv_in,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             s_ready,
   output logic             m_valid,
   output logic [7:0]       m_data,
   output logic             m_last,
   input  logic             m_ready,
   output logic [AES_W-1:0] aes_pt,
   output logic [AES_W-1:0] aes_key,
   input  logic [AES_W-1:0] aes_ct,
   output logic             busy
);

   localparam int                WAIT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CORE_LAT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES_PER_BLOCK - 1);

   state_e             state_q, state_d;
   logic [AES_W-1:0]   key_q, key_d;
   logic [AES_W-1:0]   ctr_q, ctr_d;
   logic [AES_W-1:0]   ks_q, ks_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               m_valid_q, m_valid_d;
   logic [7:0]         m_data_q, m_data_d;
   logic               m_last_q, m_last_d;
   logic [AES_W-1:0]   ctr_next;
   logic               accept;

   ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
      .blk_in  (ctr_q),
      .blk_out (ctr_next)
   );

   assign s_ready = (state_q == STREAM) && (!m_valid_q || m_ready);
   assign accept  = s_valid && s_ready;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign aes_pt  = ctr_q;
   assign aes_key = key_q;
   assign busy    = (state_q != IDLE) || m_valid_q;

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      ctr_d     = ctr_q;
      ks_d      = ks_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key_in;
               ctr_d   = iv_in;
               wait_d  = WAIT_INIT;
               state_d = GEN;
            end
         end
         GEN: begin
            if (wait_q == '0) begin
               ks_d    = aes_ct;
               idx_d   = '0;
               state_d = STREAM;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         STREAM: begin
            if (accept) begin
               idx_d = idx_q + IDX_W'(1);
               // End of message wins over block rollover; nothing is kept for the next one.
               if (s_last) begin
                  key_d   = '0;
                  ctr_d   = '0;
                  state_d = IDLE;
               end else if (idx_q == IDX_LAST) begin
                  ctr_d   = ctr_next;
                  wait_d  = WAIT_INIT;
                  state_d = GEN;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         m_valid_d = 1'b1;
         m_data_d  = s_data ^ ks_byte(ks_q, idx_q);
         m_last_d  = s_last;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         key_q     <= '0;
         ctr_q     <= '0;
         ks_q      <= '0;
         idx_q     <= '0;
         wait_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         ctr_q     <= ctr_d;
         ks_q      <= ks_d;
         idx_q     <= idx_d;
         wait_q    <= wait_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_ctr_stream : scoreboard bench with a behavioural AES-128 core and CTR model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_aes_ctr_stream;

   localparam int CORE_LAT = 2;
   localparam int CTR_W    = 32;

   logic         clk = 1'b0;
   logic         rst_n, start, s_valid, s_last, s_ready;
   logic         m_valid, m_last, m_ready, busy;
   logic [127:0] key_in, iv_in, aes_pt, aes_key, aes_ct;
   logic [7:0]   s_data, m_data;

   always #5 clk = ~clk;

   aes_ctr_stream #(.CORE_LAT(CORE_LAT), .CTR_W(CTR_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .key_in  (key_in),
      .iv_in   (iv_in),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .m_ready (m_ready),
      .aes_pt  (aes_pt),
      .aes_key (aes_key),
      .aes_ct  (aes_ct),
      .busy    (busy)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic [8:0]   exp_q[$];
   logic [7:0]   out_log[$];
   logic [7:0]   ref_log[$];
   logic [7:0]   msg_pt[64];
   logic [7:0]   sbox[256];
   bit           sbox_ready = 1'b0;
   int           rdy_mode   = 0;
   int           rdy_phase  = 0;
   int           inject_at  = -1;
   logic [127:0] gen_pt;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural AES-128 ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, aa;
      r = 8'h00; aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r = r ^ aa;
         aa = xt(aa);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0]  p, inv, s;
      logic [15:0] t;
      p = x; inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p   = gmul(p, p);
         inv = gmul(inv, p);
      end
      if (x == 8'h00) inv = 8'h00;
      s = inv ^ 8'h63;
      for (int n = 1; n < 5; n++) begin
         t = {inv, inv} << n;
         s = s ^ t[15:8];
      end
      return s;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
      logic [7:0]   st[16];
      logic [7:0]   tmp[16];
      logic [31:0]  w[44];
      logic [31:0]  t, wd;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] ct;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int j = 0; j < 16; j++) begin
         wd    = w[j/4];
         st[j] = pt[127-8*j -: 8] ^ wd[31-8*(j%4) -: 8];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int j = 0; j < 16; j++) st[j] = sbox[st[j]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tmp[r+4*c] = st[r+4*((c+r)%4)];
         st = tmp;
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int j = 0; j < 16; j++) begin
            wd    = w[4*rnd + j/4];
            st[j] = st[j] ^ wd[31-8*(j%4) -: 8];
         end
      end
      for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = st[j];
      return ct;
   endfunction

   // Counter block for the j-th keystream block of a message (32-bit low field).
   function automatic logic [127:0] ctr_add(input logic [127:0] iv, input int j);
      return {iv[127:32], iv[31:0] + 32'(j)};
   endfunction

   // Combinational core stand-in.
   always @(aes_pt or aes_key or sbox_ready) aes_ct = aes_enc(aes_key, aes_pt);

   // Downstream ready: 0 = always, 1 = one cycle on / three off, other = stalled.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         rdy_phase = (rdy_phase + 1) % 4;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (rdy_phase == 0);
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Monitor: a transfer occurs on the next rising edge when both are high here.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL out_unexpected: got %h with no byte pending", m_data);
         end else begin
            chk("out_byte", 128'({m_last, m_data}), 128'(exp_q.pop_front()));
            out_log.push_back(m_data);
         end
      end
   end

   task automatic send_byte(input logic [127:0] k, input logic [127:0] iv, input int i, input bit last);
      logic [127:0] ks;
      int           w;
      ks = aes_enc(k, ctr_add(iv, i / 16));
      s_valid = 1'b1; s_data = msg_pt[i]; s_last = last; w = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         w++;
         if (w > 200) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: byte %0d never accepted", i);
            break;
         end
      end
      if (s_ready) exp_q.push_back({last, msg_pt[i] ^ ks[127-8*(i%16) -: 8]});
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_drain();
      int cnt;
      cnt = 0;
      while (exp_q.size() != 0 && cnt < 400) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("drain", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic run_msg(input logic [127:0] k, input logic [127:0] iv, input int n_total,
                          input int n_send, input bit gaps, input bit measure);
      int edges, cnt;
      key_in = k; iv_in = iv; start = 1'b1; edges = 0;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         edges++;
         if (edges == 1 && measure) begin
            chk("gen_pt_first", aes_pt, iv);
            chk("gen_key", aes_key, k);
         end
      end while (!s_ready && edges < 100);
      if (measure) chk("start_latency", 128'(edges), 128'(CORE_LAT + 1));
      for (int i = 0; i < n_send; i++) begin
         if (gaps) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
         if (i == inject_at) begin
            key_in = ~k; iv_in = ~iv; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("ignored_start_ctr", aes_pt, ctr_add(iv, i / 16));
            chk("ignored_start_key", aes_key, k);
         end
         send_byte(k, iv, i, i == n_total - 1);
         if (measure && (i % 16 == 15) && (i != n_total - 1)) begin
            cnt = 0;
            forever begin
               @(negedge clk);
               if (s_ready || cnt > 100) break;
               if (cnt == 0) gen_pt = aes_pt;
               cnt++;
            end
            chk("gen_gap", 128'(cnt), 128'(CORE_LAT));
            chk("gen_pt_next", gen_pt, ctr_add(iv, (i + 1) / 16));
            @(posedge clk); #1;
         end
      end
      if (n_send == n_total) begin
         wait_drain();
         chk("busy_after", 128'(busy), 128'd0);
         chk("idle_not_ready", 128'(s_ready), 128'd0);
      end
   endtask

   task automatic load_f51();
      logic [127:0] p;
      p = 128'h6bc1bee22e409f96e93d7e117393172a;
      for (int j = 0; j < 16; j++) msg_pt[j] = p[127-8*j -: 8];
   endtask

   task automatic check_f51(input string name);
      logic [127:0] got;
      got = '0;
      chk({name, "_len"}, 128'(out_log.size()), 128'd16);
      for (int j = 0; j < 16 && j < out_log.size(); j++) got[127-8*j -: 8] = out_log[j];
      chk(name, got, 128'h874d6191b620e3261bef6864990db6ce);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] k_nist, iv_nist, k2, k3, iv3;
      for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
      sbox_ready = 1'b1;
      k_nist  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      iv_nist = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

      rst_n = 1'b0; start = 1'b0; key_in = '0; iv_in = '0;
      s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 128'(s_ready), 128'd0);
      chk("rst_m_valid", 128'(m_valid), 128'd0);
      chk("rst_m_data", 128'(m_data), 128'd0);
      chk("rst_m_last", 128'(m_last), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_aes_pt", aes_pt, 128'd0);
      chk("rst_aes_key", aes_key, 128'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single NIST block
      load_f51();
      out_log.delete();
      run_msg(k_nist, iv_nist, 16, 16, 1'b0, 1'b1);
      check_f51("f51_stream");

      // Two blocks, 20 bytes
      for (int j = 16; j < 20; j++) msg_pt[j] = 8'($urandom);
      out_log.delete();
      run_msg(k_nist, iv_nist, 20, 20, 1'b0, 1'b1);
      chk("multi_gen_pt", gen_pt, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
      ref_log = out_log;

      // Same message under backpressure and input gaps
      rdy_mode = 1;
      out_log.delete();
      run_msg(k_nist, iv_nist, 20, 20, 1'b1, 1'b0);
      rdy_mode = 0;
      chk("bp_len", 128'(out_log.size()), 128'(ref_log.size()));
      for (int j = 0; j < ref_log.size() && j < out_log.size(); j++)
         chk("bp_byte", 128'(out_log[j]), 128'(ref_log[j]));

      // Counter wrap of the low 32 bits
      k2 = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 17; j++) msg_pt[j] = 8'($urandom);
      run_msg(k2, 128'h00112233445566778899aabbffffffff, 17, 17, 1'b0, 1'b1);
      chk("wrap_gen_pt", gen_pt, 128'h00112233445566778899aabb00000000);

      // Early last with a start pulse during STREAM
      k3  = {$urandom, $urandom, $urandom, $urandom};
      iv3 = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 16; j++) msg_pt[j] = 8'($urandom);
      inject_at = 3;
      out_log.delete();
      run_msg(k3, iv3, 6, 6, 1'b0, 1'b0);
      inject_at = -1;
      chk("early_last_count", 128'(out_log.size()), 128'd6);

      // Reset in the middle of a message with a held output byte
      run_msg(k3, iv3, 16, 8, 1'b0, 1'b0);
      wait_drain();
      rdy_mode = 2;
      repeat (2) begin @(posedge clk); #1; end
      send_byte(k3, iv3, 8, 1'b0);
      chk("hold_valid", 128'(m_valid), 128'd1);
      if (exp_q.size() != 0) chk("hold_data", 128'(m_data), 128'(exp_q[0][7:0]));
      s_valid = 1'b1; s_data = msg_pt[9];
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_m_valid", 128'(m_valid), 128'd0);
      chk("midrst_s_ready", 128'(s_ready), 128'd0);
      chk("midrst_aes_pt", aes_pt, 128'd0);
      chk("midrst_aes_key", aes_key, 128'd0);
      chk("midrst_busy", 128'(busy), 128'd0);
      exp_q.delete();
      s_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      rdy_mode = 0;
      @(posedge clk); #1;

      load_f51();
      out_log.delete();
      run_msg(k_nist, iv_nist, 16, 16, 1'b0, 1'b1);
      check_f51("f51_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
